// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa.sv
// One-bit full adder: the only arithmetic element of the serial adder.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one operand bit per RUN cycle through a single full adder,
// LSB first, result assembled MSB-inward in a right-shifting sum register.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  fa u_fa (
    .a_i(a_q[0]),
    .b_i(b_q[0]),
    .c_i(carry_q),
    .s_o(fa_s),
    .c_o(fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result and carry come straight from state, so they hold through IDLE.
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an a+b+cin reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Drives one accepted start, then waits (bounded) for done; lat = edges from accept to done.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        output logic [W-1:0] s, output logic co, output int lat);
    wait_idle();
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    s = sum; co = cout;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b done=%0b cout=%0b sum=%h expected all 0", busy, done, cout, sum);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] xs[3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [W-1:0] ys[3] = '{8'h33, 8'h01, 8'hFF};
    logic         cs[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] s;
    logic         co;
    int           lat;
    logic [W:0]   exp;
    for (int k = 0; k < 3; k++) begin
      exp = model(xs[k], ys[k], cs[k]);
      run_op(xs[k], ys[k], cs[k], s, co, lat);
      checks++;
      if (lat != W) begin
        errors++;
        $display("FAIL vec%0d_latency got %0d expected %0d", k, lat, W);
      end
      checks++;
      if ({co, s} !== exp) begin
        errors++;
        $display("FAIL vec%0d_result got cout=%0b sum=%h expected cout=%0b sum=%h", k, co, s, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_done_width got done=%0b busy=%0b expected 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int extra = 0;
    wait_idle();
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    for (int i = 5; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != W || sum !== 8'h30 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result got lat=%0d cout=%0b sum=%h expected lat=%0d cout=0 sum=30", lat, cout, sum, W);
    end
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++;
    if (extra != 0 || sum !== 8'h30) begin
      errors++;
      $display("FAIL ignore_start_no_second_done got pulses=%0d sum=%h expected 0 30", extra, sum);
    end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int pulses = 0;
    wait_idle();
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        checks++;
        if (sum !== 8'h02 || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result got cout=%0b sum=%h expected cout=0 sum=02", cout, sum);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != W + 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d expected %0d", cyc - last, W + 2);
          end
        end
        last = cyc;
      end
    end
    start = 1'b0;
    checks++;
    if (pulses < 4) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d expected >=4", pulses);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s;
    logic         co;
    int           lat;
    int           seen = 0;
    wait_idle();
    a = W'($urandom); b = W'($urandom); cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%0b done=%0b cout=%0b sum=%h expected all 0", busy, done, cout, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_abort got active_cycles=%0d expected 0", seen);
    end
    run_op(8'h0F, 8'h01, 1'b0, s, co, lat);
    checks++;
    if (lat != W || s !== 8'h10 || co !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op got lat=%0d cout=%0b sum=%h expected lat=%0d cout=0 sum=10", lat, co, s, W);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, s;
    logic         c, co;
    logic [W:0]   exp;
    int           lat;
    for (int n = 0; n < 1000; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom);
      exp = model(x, y, c);
      run_op(x, y, c, s, co, lat);
      checks++;
      if (lat != W || {co, s} !== exp) begin
        errors++;
        $display("FAIL random_op%0d a=%h b=%h cin=%0b got lat=%0d cout=%0b sum=%h expected lat=%0d cout=%0b sum=%h",
                 n, x, y, c, lat, co, s, W, exp[W], exp[W-1:0]);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (n % 100 == 0) begin
        checks++;
        if ({cout, sum} !== exp) begin
          errors++;
          $display("FAIL random_hold%0d got cout=%0b sum=%h expected cout=%0b sum=%h", n, cout, sum, exp[W], exp[W-1:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH, first operand; captured on accepted start.
REQ-006 The block SHALL have port b, input, WIDTH, second operand; captured on accepted start.
REQ-007 The block SHALL have port cin, input, 1, carry-in; captured on accepted start.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 The block SHALL have port sum, output, WIDTH, result; valid from done until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1, final carry-out; same validity as sum.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, with transitions IDLE->RUN on start=1, RUN->DONE after WIDTH RUN cycles, DONE->IDLE unconditionally.
REQ-013 On an accepted start, a and b SHALL load into shift registers, cin into the carry register, the bit counter to 0, and the sum shift register to 0.
REQ-014 Each RUN cycle SHALL feed operand-register bit 0 of both operands plus the carry register into the full adder, shift both operand registers right by one, shift the sum register right with the adder sum entering the MSB, load the adder carry into the carry register, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles, exiting when counter = WIDTH-1; the counter width SHALL be clog2(WIDTH).
REQ-016 done SHALL be high for exactly one cycle (state DONE), beginning at the WIDTH-th rising edge after the edge that accepted start.
REQ-017 sum and cout SHALL hold their final values from DONE until the next accepted start, and SHALL NOT change during IDLE.
REQ-018 start in RUN or DONE SHALL be ignored, with no effect on operands or result.
REQ-019 Minimum spacing between accepted starts SHALL be WIDTH+2 cycles; start held high SHALL be re-accepted on the first IDLE cycle.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the overflow bit on cout, so that {cout,sum} = a+b+cin.

Reset
REQ-021 rst=1 SHALL immediately, without waiting for clk, force state IDLE, counter 0, all shift and carry registers 0, busy=0, done=0, sum=0 and cout=0.
REQ-022 rst asserted mid-RUN SHALL abort the operation with no done pulse, and the first start after rst deasserts SHALL complete normally.

Structure
REQ-023 Shared package serial_add_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the constant DEFAULT_WIDTH=8.
REQ-024 The existing one-bit full adder fa SHALL be instantiated exactly once as the sole arithmetic element, with no other adder logic in the block.

Verification
REQ-025 WIDTH=8, a=0x5A, b=0x33, cin=0 -> sum=0x8D and cout=0, with done at the 8th edge after the accepting edge.
REQ-026 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-027 Start a=0x10, b=0x20; pulse start with a=0xAA, b=0x55 during RUN -> result 0x30 with cout=0, and no second done pulse.
REQ-028 start held high continuously with a=0x01, b=0x01 -> done pulses every 10 cycles, each with sum=0x02.
REQ-029 rst asserted mid-cycle on the 4th RUN cycle -> busy, done, sum and cout drop to 0 before the next edge; after release, a=0x0F, b=0x01 -> sum=0x10.
REQ-030 Random a, b and cin over 1000 operations -> {cout,sum} equals a+b+cin for each operation.
